// File: rtl/mull_unit.sv
// Iterative 32x32->64 multiplier for UMULL/SMULL: radix-2 shift-add on operand magnitudes,
// followed by a single sign-correction step. Fixed latency of WIDTH+2 cycles from launch to done.
module mull_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             n_flag,
  output logic             z_flag
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    product;

  // The most negative operand maps to itself, which is correct when read as unsigned.
  always_comb begin
    mag_a   = (is_signed & a[WIDTH-1]) ? -a : a;
    mag_b   = (is_signed & b[WIDTH-1]) ? -b : b;
    product = neg ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= StIdle;
      busy   <= 1'b0;
      done   <= 1'b0;
      lo     <= '0;
      hi     <= '0;
      n_flag <= 1'b0;
      z_flag <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            state  <= StCalc;
            busy   <= 1'b1;
            mcand  <= PW'(mag_a);
            mplier <= mag_b;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end else begin
            state <= StIdle;
          end
        end
        StCalc: begin
          // Shifting the multiplicand each step is equivalent to adding mag_a << cnt.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LastCnt) state <= StFix;
        end
        StFix: begin
          lo     <= product[WIDTH-1:0];
          hi     <= product[PW-1:WIDTH];
          n_flag <= product[PW-1];
          z_flag <= (product == '0);
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= StDone;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mull_unit.sv
// Directed self-checking bench for mull_unit with hand-computed products.
module tb_mull_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        n_flag;
  logic        z_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mull_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_signed(is_signed),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .lo       (lo),
    .hi       (hi),
    .n_flag   (n_flag),
    .z_flag   (z_flag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge; the next edge samples the launch.
  task automatic start_op(input logic s, input logic [31:0] x, input logic [31:0] y);
    start     = 1'b1;
    is_signed = s;
    a         = x;
    b         = y;
  endtask

  // Counts edges (launch edge included) until done is seen high.
  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (done) break;
      if (lat >= 100) begin
        check("done_timeout", 64'(lat), 64'd34);
        break;
      end
    end
  endtask

  task automatic mul(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                     input logic exp_n, input logic exp_z);
    int lat;
    start_op(s, x, y);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'd34);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_n"}, 64'(n_flag), 64'(exp_n));
    check({tag, "_z"}, 64'(z_flag), 64'(exp_z));
  endtask

  initial begin
    int lat;
    int lat2;
    int seen;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_res", {hi, lo}, 64'd0);
    check("rst_flags", 64'({n_flag, z_flag}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Launch then confirm busy in the first CALC cycle.
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_calc", 64'(busy), 64'd1);
    wait_done(lat);
    check("umax_lat", 64'(lat + 1), 64'd34);
    check("umax_busy", 64'(busy), 64'd0);
    check("umax_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    check("umax_nz", 64'({n_flag, z_flag}), 64'b10);
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done), 64'd0);

    mul("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1'b0);
    mul("u_m3x5", 1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 1'b0);
    mul("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
    mul("s_m1m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    mul("u_zero", 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    mul("s_min0", 1'b1, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);

    // start during an operation must be ignored.
    start_op(1'b0, 32'd100, 32'd200);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    start_op(1'b1, 32'd2, 32'd3);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("ign_lat", 64'(lat + 10), 64'd34);
    check("ign_res", {hi, lo}, 64'd20000);

    // Back-to-back launch from the DONE cycle; previous result held meanwhile.
    start_op(1'b0, 32'd7, 32'd6);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_hold", {hi, lo}, 64'd20000);
    wait_done(lat2);
    check("b2b_lat", 64'(lat2 + 1), 64'd34);
    check("b2b_res", {hi, lo}, 64'd42);

    // Reset in the middle of CALC aborts with no done.
    start_op(1'b1, 32'hFFFF_FFFD, 32'd5);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_res", {hi, lo}, 64'd0);
    check("abort_flags", 64'({n_flag, z_flag}), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort_nodone", 64'(seen), 64'd0);
    mul("post_rst", 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
